// File: rtl/ex_mul_pkg.sv
// ex_mul_pkg: shared definitions for the iterative shift-add multiplier.
//   state_t     : FSM encoding (IDLE, BUSY, DONE)
//   DEF_WIDTH   : default operand/result width
//   cnt_width() : step-counter width for a given operand width, clog2(w+1)
//   CNT_W       : step-counter width for DEF_WIDTH
package ex_mul_pkg;

  localparam int DEF_WIDTH = 32;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/ex_mul_dp.sv
// ex_mul_dp: operand, accumulator and step-counter registers of the
// shift-add multiplier, plus the result/destination output registers.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   load          : capture operands and destination, clear acc, counter=WIDTH
//   step          : perform one shift-add step
//   rs_data       : multiplicand
//   rt_data       : multiplier
//   rd_addr       : destination register to pair with the product
//   last          : counter is 1, the current step is the final one
//   result        : low WIDTH bits of the most recent completed product
//   rd_result     : destination register paired with result
module ex_mul_dp
  import ex_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [4:0]       rd_addr,
  output logic             last,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_result
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;
  logic [4:0]       rd_lat;

  // Accumulator is only WIDTH bits wide, so the sum wraps modulo 2^WIDTH and
  // the low word is correct for signed and unsigned operands alike.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign last     = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      rd_lat    <= '0;
      result    <= '0;
      rd_result <= '0;
    end else if (load) begin
      mcand  <= rs_data;
      mplier <= rt_data;
      rd_lat <= rd_addr;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      // The final step publishes the finished sum directly, on the same edge
      // that moves the FSM into DONE.
      if (last) begin
        result    <= acc_next;
        rd_result <= rd_lat;
      end
    end
  end

endmodule

// File: rtl/ex_mul_unit.sv
// ex_mul_unit: multi-cycle MUL execution unit for the EX stage. A MUL held
// in ID_EX is captured, multiplied over WIDTH shift-add cycles while the
// front of the pipeline is stalled, and the product is presented with a
// one-cycle valid pulse.
// Ports:
//   clk_i      : clock (rising edge)
//   rst_i      : asynchronous active-high reset
//   start_i    : ID_EX holds a MUL this cycle
//   flush_i    : abort any multiply in progress
//   rs_data_i  : multiplicand
//   rt_data_i  : multiplier
//   rd_addr_i  : destination register of the MUL
//   stall_o    : hold PC, IF_ID and ID_EX
//   valid_o    : one-cycle pulse, product available
//   result_o   : low WIDTH bits of the product
//   rd_addr_o  : destination register paired with result_o
module ex_mul_unit
  import ex_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic [4:0]       rd_addr_i,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [4:0]       rd_addr_o
);

  state_t state;
  state_t state_next;
  logic   load;
  logic   step;
  logic   last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i && !flush_i) begin
          load       = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (flush_i) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (last) begin
            state_next = DONE;
          end
        end
      end
      // start_i is ignored here: the MUL just completed is still sitting in
      // ID_EX during this cycle and must not be re-issued.
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign stall_o = !rst_i && (((state == IDLE) && start_i && !flush_i) || (state == BUSY));

  // A flush arriving in the DONE cycle suppresses the pulse.
  assign valid_o = (state == DONE) && !flush_i;

  ex_mul_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk       (clk_i),
    .rst       (rst_i),
    .load      (load),
    .step      (step),
    .rs_data   (rs_data_i),
    .rt_data   (rt_data_i),
    .rd_addr   (rd_addr_i),
    .last      (last),
    .result    (result_o),
    .rd_result (rd_addr_o)
  );

endmodule

// File: tb/tb_ex_mul_unit.sv
// tb_ex_mul_unit: directed-vector bench for ex_mul_unit (WIDTH=32).
module tb_ex_mul_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [4:0]  rd;
  logic        stall;
  logic        valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ex_mul_unit #(
    .WIDTH(32)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .flush_i   (flush),
    .rs_data_i (rs),
    .rt_data_i (rt),
    .rd_addr_i (rd),
    .stall_o   (stall),
    .valid_o   (valid),
    .result_o  (result),
    .rd_addr_o (rd_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Entered just after a rising edge with the unit idle. Holds start high
  // (as a stalled ID_EX would) until the DONE cycle has been seen, then
  // drops it just after the following edge.
  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rdv, input logic [31:0] exp,
                        output int vcyc);
    int stalls;
    bit got;
    stalls = 0;
    got    = 1'b0;
    vcyc   = 0;
    start  = 1'b1;
    rs     = a;
    rt     = b;
    rd     = rdv;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (valid) begin
        got  = 1'b1;
        vcyc = cyc;
        chk({tag, " result"}, result, exp);
        chk({tag, " rd"}, 32'(rd_out), 32'(rdv));
        chk({tag, " stall_cycles"}, 32'(stalls), 32'd33);
        chk({tag, " stall_in_done"}, 32'(stall), 32'd0);
      end else begin
        if (stall) stalls++;
        @(posedge clk);
        #1;
      end
    end
    if (!got) chk({tag, " timeout_valid_seen"}, 32'(got), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    int v1;
    int v2;
    int vcount;

    rst   = 1'b1;
    start = 1'b1;
    flush = 1'b0;
    rs    = 32'd0;
    rt    = 32'd0;
    rd    = 5'd0;

    // Reset state, with start high to show stall is held off.
    @(posedge clk);
    #1;
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst valid", 32'(valid), 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst rd", 32'(rd_out), 32'd0);
    chk("rst state", 32'(dut.state), 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic product, latency and single-cycle valid.
    do_mul("7x6", 32'd7, 32'd6, 5'd5, 32'd42, v1);
    @(negedge clk);
    chk("7x6 valid_single", 32'(valid), 32'd0);
    chk("7x6 result_hold", result, 32'd42);
    @(posedge clk);
    #1;

    // Wrap-around and zero operands.
    do_mul("ffff x ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001, v1);
    do_mul("-3 x 5", 32'hFFFF_FFFD, 32'd5, 5'd31, 32'hFFFF_FFF1, v1);
    do_mul("0 x 12345678", 32'd0, 32'h1234_5678, 5'd10, 32'd0, v1);

    // Back-to-back issue: second MUL presented in the IDLE cycle after DONE.
    do_mul("3x4", 32'd3, 32'd4, 5'd1, 32'd12, v1);
    do_mul("5x5", 32'd5, 32'd5, 5'd2, 32'd25, v2);
    chk("b2b spacing", 32'(v2 - v1), 32'd34);

    // Flush and start together in IDLE: flush wins.
    start = 1'b1;
    flush = 1'b1;
    rs    = 32'd9;
    rt    = 32'd9;
    rd    = 5'd7;
    #1;
    chk("idle flush stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    chk("idle flush state", 32'(dut.state), 32'd0);
    flush = 1'b0;

    // Flush in BUSY cycle 10: result and rd keep the 5x5 values.
    @(posedge clk);
    #1;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("busy10 stall", 32'(stall), 32'd1);
    start = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush state", 32'(dut.state), 32'd0);
    chk("flush stall", 32'(stall), 32'd0);
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    chk("flush no_valid", 32'(vcount), 32'd0);
    chk("flush result_kept", result, 32'd25);
    chk("flush rd_kept", 32'(rd_out), 32'd2);

    // Reset raised between edges mid-BUSY.
    @(posedge clk);
    #1;
    start = 1'b1;
    rs    = 32'd8;
    rt    = 32'd8;
    rd    = 5'd3;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst stall", 32'(stall), 32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst rd", 32'(rd_out), 32'd0);
    chk("midrst valid", 32'(valid), 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst state", 32'(dut.state), 32'd0);
    do_mul("2x3", 32'd2, 32'd3, 5'd9, 32'd6, v1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
